n_bits_demux_scoreboard: RTL and testbench

- Parametrised register-file write-enable demux with a pending-write scoreboard, for the datapath issue/writeback boundary.
- Writeback path decodes WB_DST into a registered one-hot write enable for the register file.
- Issue path decodes the destination into a per-register busy bit. It holds issue off (ISSUE_READY low) while a source or destination register has a write outstanding.

---
 rtl/n_bits_demux_scoreboard.sv | 108 ++++++++++
 tb/tb_n_bits_demux_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/n_bits_demux_scoreboard.sv
// Register-file write-enable demux with pending-write scoreboard.
// Writeback decodes WB_DST to a registered one-hot enable; issue marks destinations busy.
module n_bits_demux_scoreboard #(
    parameter int SEL_W              = 5,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               ISSUE_VALID,
    output logic               ISSUE_READY,
    input  logic               ISSUE_WE,
    input  logic [SEL_W-1:0]   ISSUE_DST,
    input  logic [SEL_W-1:0]   ISSUE_SRC_A,
    input  logic [SEL_W-1:0]   ISSUE_SRC_B,
    input  logic               WB_VALID,
    input  logic [SEL_W-1:0]   WB_DST,
    output logic [(1<<SEL_W)-1:0] WE_ONEHOT,
    output logic [(1<<SEL_W)-1:0] BUSY,
    output logic [SEL_W:0]     BUSY_COUNT,
    output logic               WB_ERR
);

    localparam int N = 1 << SEL_W;
    localparam logic [SEL_W:0] CNT_ONE = {{SEL_W{1'b0}}, 1'b1};

    function automatic logic [N-1:0] f_onehot(input logic [SEL_W-1:0] sel);
        logic [N-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    logic [N-1:0]   r_we_onehot;
    logic [N-1:0]   r_busy;
    logic [SEL_W:0] r_busy_cnt;
    logic           r_wb_err;

    logic [N-1:0]   w_eff_busy;
    logic           w_issue_accept;
    logic           w_set_en;
    logic           w_clr_en;
    logic           w_inc;
    logic           w_dec;
    logic           w_wb_zero;
    logic           w_dst_zero;
    logic [N-1:0]   w_busy_nxt;

    assign w_wb_zero  = (ZERO_REG_HARDWIRED != 0) && (WB_DST == '0);
    assign w_dst_zero = (ZERO_REG_HARDWIRED != 0) && (ISSUE_DST == '0);

    // Same-cycle writeback is forwarded so a dependent issue need not wait a cycle.
    always_comb begin
        w_eff_busy = r_busy;
        if (WB_VALID) begin
            w_eff_busy[WB_DST] = 1'b0;
        end
        if (ZERO_REG_HARDWIRED != 0) begin
            w_eff_busy[0] = 1'b0;
        end
    end

    assign ISSUE_READY = !(w_eff_busy[ISSUE_SRC_A] | w_eff_busy[ISSUE_SRC_B] |
                           (ISSUE_WE & w_eff_busy[ISSUE_DST]));

    assign w_issue_accept = ISSUE_VALID & ISSUE_READY;
    assign w_set_en       = w_issue_accept & ISSUE_WE & !w_dst_zero;
    assign w_clr_en       = WB_VALID & !w_wb_zero;

    // A new issue to the register being written back supersedes the older writer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr_en) begin
            w_busy_nxt[WB_DST] = 1'b0;
        end
        if (w_set_en) begin
            w_busy_nxt[ISSUE_DST] = 1'b1;
        end
    end

    assign w_inc = w_set_en & !r_busy[ISSUE_DST];
    assign w_dec = w_clr_en & r_busy[WB_DST] & !(w_set_en && (ISSUE_DST == WB_DST));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_we_onehot <= '0;
            r_busy      <= '0;
            r_busy_cnt  <= '0;
            r_wb_err    <= 1'b0;
        end else begin
            r_we_onehot <= w_clr_en ? f_onehot(WB_DST) : '0;
            r_busy      <= w_busy_nxt;
            case ({w_inc, w_dec})
                2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
                2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
                default: r_busy_cnt <= r_busy_cnt;
            endcase
            if (w_clr_en && !r_busy[WB_DST]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign WE_ONEHOT  = r_we_onehot;
    assign BUSY       = r_busy;
    assign BUSY_COUNT = r_busy_cnt;
    assign WB_ERR     = r_wb_err;

endmodule

// File: tb/tb_n_bits_demux_scoreboard.sv
// Directed bench for n_bits_demux_scoreboard: a SEL_W=5 and a SEL_W=3 instance.
module tb_n_bits_demux_scoreboard;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;

    logic        ISSUE_VALID = 1'b0, ISSUE_WE = 1'b0, WB_VALID = 1'b0;
    logic [4:0]  ISSUE_DST = '0, ISSUE_SRC_A = '0, ISSUE_SRC_B = '0, WB_DST = '0;
    logic        ISSUE_READY, WB_ERR;
    logic [31:0] WE_ONEHOT, BUSY;
    logic [5:0]  BUSY_COUNT;

    logic        s_issue_valid = 1'b0, s_issue_we = 1'b0, s_wb_valid = 1'b0;
    logic [2:0]  s_issue_dst = '0, s_src_a = '0, s_src_b = '0, s_wb_dst = '0;
    logic        s_issue_ready, s_wb_err;
    logic [7:0]  s_we_onehot, s_busy;
    logic [3:0]  s_busy_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    n_bits_demux_scoreboard #(.SEL_W(5), .ZERO_REG_HARDWIRED(1)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY), .ISSUE_WE(ISSUE_WE),
        .ISSUE_DST(ISSUE_DST), .ISSUE_SRC_A(ISSUE_SRC_A), .ISSUE_SRC_B(ISSUE_SRC_B),
        .WB_VALID(WB_VALID), .WB_DST(WB_DST),
        .WE_ONEHOT(WE_ONEHOT), .BUSY(BUSY), .BUSY_COUNT(BUSY_COUNT), .WB_ERR(WB_ERR)
    );

    n_bits_demux_scoreboard #(.SEL_W(3), .ZERO_REG_HARDWIRED(1)) u_dut3 (
        .CLK(CLK), .RESET_N(RESET_N),
        .ISSUE_VALID(s_issue_valid), .ISSUE_READY(s_issue_ready), .ISSUE_WE(s_issue_we),
        .ISSUE_DST(s_issue_dst), .ISSUE_SRC_A(s_src_a), .ISSUE_SRC_B(s_src_b),
        .WB_VALID(s_wb_valid), .WB_DST(s_wb_dst),
        .WE_ONEHOT(s_we_onehot), .BUSY(s_busy), .BUSY_COUNT(s_busy_count), .WB_ERR(s_wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic v, input logic we, input logic [4:0] dst,
                         input logic [4:0] sa, input logic [4:0] sb);
        ISSUE_VALID = v; ISSUE_WE = we; ISSUE_DST = dst; ISSUE_SRC_A = sa; ISSUE_SRC_B = sb;
    endtask

    task automatic wb(input logic v, input logic [4:0] dst);
        WB_VALID = v; WB_DST = dst;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", BUSY, 32'h0);
        chk("rst_cnt", 32'(BUSY_COUNT), 32'd0);
        chk("rst_we", WE_ONEHOT, 32'h0);
        chk("rst_err", 32'(WB_ERR), 32'd0);
        chk("rst3_cnt", 32'(s_busy_count), 32'd0);
        RESET_N = 1'b1;
        issue(1'b0, 1'b1, 5'd31, 5'd3, 5'd17);
        #1;
        chk("idle_ready", 32'(ISSUE_READY), 32'd1);
        tick();
        chk("idle_busy", BUSY, 32'h0);

        // Issue to r5, then a dependent reader with same-cycle writeback forwarding.
        issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        tick();
        chk("r5_busy", BUSY, 32'h0000_0020);
        chk("r5_cnt", 32'(BUSY_COUNT), 32'd1);
        issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
        #1;
        chk("r5_stall", 32'(ISSUE_READY), 32'd0);
        wb(1'b1, 5'd5);
        #1;
        chk("r5_fwd", 32'(ISSUE_READY), 32'd1);
        tick();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        wb(1'b0, 5'd0);
        chk("r5_we", WE_ONEHOT, 32'h0000_0020);
        chk("r5_clr", BUSY, 32'h0);
        chk("r5_cnt0", 32'(BUSY_COUNT), 32'd0);
        tick();
        chk("we_idle", WE_ONEHOT, 32'h0);

        // Same-edge set and clear of r7: set wins.
        issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        tick();
        chk("r7_busy", BUSY, 32'h0000_0080);
        wb(1'b1, 5'd7);
        #1;
        chk("r7_ready", 32'(ISSUE_READY), 32'd1);
        tick();
        chk("r7_keep", BUSY, 32'h0000_0080);
        chk("r7_cnt", 32'(BUSY_COUNT), 32'd1);
        chk("r7_we", WE_ONEHOT, 32'h0000_0080);
        chk("r7_err", 32'(WB_ERR), 32'd0);
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("r7_clr", BUSY, 32'h0);
        chk("r7_cnt0", 32'(BUSY_COUNT), 32'd0);

        // Set and clear on different registers in one edge: net count unchanged.
        wb(1'b0, 5'd0);
        issue(1'b1, 1'b1, 5'd2, 5'd0, 5'd0);
        tick();
        issue(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
        wb(1'b1, 5'd2);
        tick();
        chk("net_busy", BUSY, 32'h0000_0010);
        chk("net_cnt", 32'(BUSY_COUNT), 32'd1);
        chk("net_we", WE_ONEHOT, 32'h0000_0004);
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd4);
        tick();
        chk("net_cnt0", 32'(BUSY_COUNT), 32'd0);

        // Hardwired register 0.
        wb(1'b0, 5'd0);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        tick();
        chk("z_busy", BUSY, 32'h0);
        chk("z_cnt", 32'(BUSY_COUNT), 32'd0);
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd0);
        tick();
        chk("z_we", WE_ONEHOT, 32'h0);
        chk("z_err", 32'(WB_ERR), 32'd0);
        wb(1'b1, 5'd9);
        tick();
        chk("e9_err", 32'(WB_ERR), 32'd1);
        chk("e9_we", WE_ONEHOT, 32'h0000_0200);
        chk("e9_cnt", 32'(BUSY_COUNT), 32'd0);
        wb(1'b0, 5'd0);
        tick();
        chk("e9_sticky", 32'(WB_ERR), 32'd1);
        chk("e9_we0", WE_ONEHOT, 32'h0);

        // Fill r1..r31.
        for (int d = 1; d < 32; d++) begin
            issue(1'b1, 1'b1, 5'(d), 5'd0, 5'd0);
            tick();
        end
        chk("full_cnt", 32'(BUSY_COUNT), 32'd31);
        chk("full_busy", BUSY, 32'hFFFF_FFFE);
        issue(1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
        #1;
        chk("full_stall", 32'(ISSUE_READY), 32'd0);
        issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        chk("full_r0_ready", 32'(ISSUE_READY), 32'd1);
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd12);
        tick();
        chk("full_wb_cnt", 32'(BUSY_COUNT), 32'd30);
        chk("full_wb_we", WE_ONEHOT, 32'h0000_1000);
        wb(1'b0, 5'd0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("async_busy", BUSY, 32'h0);
        chk("async_cnt", 32'(BUSY_COUNT), 32'd0);
        chk("async_we", WE_ONEHOT, 32'h0);
        chk("async_err", 32'(WB_ERR), 32'd0);
        tick();
        RESET_N = 1'b1;
        tick();

        // SEL_W=3 instance.
        s_issue_valid = 1'b1; s_issue_we = 1'b1; s_issue_dst = 3'd6;
        tick();
        chk("s3_busy", 32'(s_busy), 32'h40);
        chk("s3_cnt1", 32'(s_busy_count), 32'd1);
        s_issue_valid = 1'b0; s_issue_we = 1'b0;
        s_wb_valid = 1'b1; s_wb_dst = 3'd6;
        tick();
        chk("s3_we", 32'(s_we_onehot), 32'h40);
        chk("s3_cnt0", 32'(s_busy_count), 32'd0);
        chk("s3_err", 32'(s_wb_err), 32'd0);
        s_wb_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
